imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Byte-stream boot loader that acts as the writer of the processor's instruction memory port, the side the processor never drives itself. It receives a length-prefixed program image over a valid/ready byte channel, assembles little-endian 32-bit words and writes them into instruction memory through the mwa/mwd/mwr write interface. It holds the processor in reset until the image is fully written, then releases it.

## Interface
- BASE_ADDR, 32'h0000_0000, address of the first word written
- ADDR_STEP, 4, address increment per word (byte addressing, MIPS convention)
- MAX_WORDS, 256, largest accepted image length in words
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- in_data  input  8  image byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- boot_start  input  1  single-cycle pulse; restarts loading from DONE or ERR
- mwa_i  output  32  instruction memory write address
- mwd_i  output  32  instruction memory write data
- mwr_i  output  1  instruction memory write strobe, one cycle per word
- cpu_reset  output  1  active-high reset to processor, high while loading
- done  output  1  image loaded and verified
- error  output  1  image rejected

## Operation
- Byte accepted only when in_valid && in_ready. Bytes 0..3 of each word map to bits [7:0],[15:8],[23:16],[31:24].
- States: LEN, DATA, CHK, DONE, ERR. LEN is entered immediately after reset release.
- LEN: collect one length word N. N == 0 -> DONE (CHK when BOOT_CHECKSUM_EN). N > MAX_WORDS -> ERR. Otherwise, clear the word index k and go to DATA.
- DATA: on the 4th byte of word k, register mwd_i = word and mwa_i = BASE_ADDR + ADDR_STEP*k (32-bit, wraps modulo 2^32), then pulse mwr_i. After word N-1 -> DONE (or CHK).
- DONE: done=1, cpu_reset=0, in_ready=0. ERR: error=1, cpu_reset=1, in_ready=0.
- boot_start in DONE or ERR: clear done/error, assert cpu_reset, clear the byte and word counters, go to LEN. boot_start is ignored in other states.
- A partial word left at the end of a stream is never written. The loader waits in its current state indefinitely; there is no timeout.
- Asserting reset mid-image abandons the image. Words already written stay in memory.

## Timing
- Reset values: in_ready=0, mwa_i=BASE_ADDR, mwd_i=0, mwr_i=0, cpu_reset=1, done=0, error=0. State resets to LEN. in_ready=1 from the first clock edge after reset deasserts.
- in_ready is registered and equals 1 in LEN, DATA and CHK. No back-pressure is applied mid-image; one byte per cycle is sustained.
- mwr_i is high exactly the cycle after the 4th byte of a word is accepted. mwa_i and mwd_i are valid in that cycle and hold until the next write.
- Throughput: at most one write every 4 cycles.
- The DONE or ERR transition is registered on the edge after the final byte. Writes complete on that same edge (or on the edge after the last data byte when a checksum word follows).
  - done rises, and cpu_reset falls, one cycle after the last mwr_i pulse.
  - error rises the cycle after the offending byte.
- boot_start takes effect on the next edge: cpu_reset=1 and in_ready=1 in the following cycle.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - A trailing 32-bit checksum word follows the data. It is also sent when N == 0.
  - The checksum is the XOR of all N data words, with seed 0.
  - CHK state compares it: equal -> DONE; mismatch -> ERR.
  - Data words are still written before the check. cpu_reset stays high on mismatch.
- BOOT_CHECKSUM_EN undefined: no CHK state and no checksum register. DONE follows the last data word directly.

## Test plan
- Reset then stream N=2, words 0x2001_0005, 0x0000_000C:
  - mwr_i pulses twice, writing mwa_i=0x0 then 0x4 with those values.
  - done=1 and cpu_reset=0 one cycle after the 2nd pulse.
- N=0: done=1 with no mwr_i pulse. With BOOT_CHECKSUM_EN, the checksum word 0x0 must also be sent.
- N=MAX_WORDS+1 (257): error=1, no writes, cpu_reset stays 1, in_ready=0.
- BOOT_CHECKSUM_EN, N=2, words 0xFFFF_0000 and 0x0000_FFFF:
  - checksum 0xFFFF_FFFF -> done=1.
  - checksum 0x0 -> error=1, cpu_reset=1.
- in_valid toggled every other cycle across N=3: all three writes occur with the correct data, and each mwr_i pulse lasts exactly one cycle.
- reset asserted after 6 bytes, released, new N=1 image 0x1234_5678: a single write to BASE_ADDR with 0x1234_5678. Then pulse boot_start -> cpu_reset=1 and the loader accepts a fresh length word.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Writes a length-prefixed, little-endian byte-stream program image into
// instruction memory through the mwa_i/mwd_i/mwr_i write port. The processor
// stays in reset (cpu_reset=1) until the whole image has been written.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, a trailing 32-bit XOR checksum word follows the data.
//   This word is also sent when N == 0. A CHK state compares the word against
//   the XOR of all data words. A match goes to DONE; a mismatch goes to ERR.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is a register. It is 1 in every collecting state, and the loader
// never applies back-pressure mid-image. The producer may hold in_valid
// across cycles freely. in_data is sampled only when the transfer happens.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        boot_start,
    output logic [31:0] mwa_i,
    output logic [31:0] mwd_i,
    output logic        mwr_i,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [2:0]  o_dbg_state
);

    // Word index / length width: large enough to hold MAX_WORDS itself.
    localparam int unsigned KW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
`ifdef BOOT_CHECKSUM_EN
        ST_CHK  = 3'd2,
`endif
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [1:0]   r_byte_cnt;
    logic [23:0]  r_buf;
    logic [KW-1:0] r_len;
    logic [KW-1:0] r_k;
    logic [31:0]  r_addr;
    logic         r_fin;
    logic         r_in_ready;
    logic [31:0]  r_mwa;
    logic [31:0]  r_mwd;
    logic         r_mwr;
    logic         r_cpu_reset;
    logic         r_done;
    logic         r_error;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]  r_chk;
`endif

    logic         w_accept;
    logic         w_word_end;
    logic [31:0]  w_word;
    logic         w_len_zero;
    logic         w_len_big;
    logic         w_last_word;
    logic         w_wr;
    logic         w_fin_set;
    logic         w_restart;
    logic         w_in_ready_nxt;

    assign w_accept    = in_valid && r_in_ready;
    assign w_word_end  = w_accept && (r_byte_cnt == 2'd3);
    // Byte 3 arrives live; bytes 0..2 are already buffered.
    assign w_word      = {in_data, r_buf};
    assign w_len_zero  = (w_word == 32'd0);
    assign w_len_big   = (w_word > 32'(MAX_WORDS));
    assign w_last_word = (r_k == (r_len - KW'(1)));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, write strobe request and restart detection.
    // Without a checksum, the last data word raises r_fin for one cycle while
    // its write is on the port. DONE follows one edge later, so done rises
    // one cycle after the final mwr_i pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_fin_set   = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_LEN: begin
                if (w_word_end) begin
                    if (w_len_zero) begin
`ifdef BOOT_CHECKSUM_EN
                        w_state_nxt = ST_CHK;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else if (w_len_big) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (r_fin) begin
                    w_state_nxt = ST_DONE;
                end else if (w_word_end) begin
                    w_wr = 1'b1;
                    if (w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
                        w_state_nxt = ST_CHK;
`else
                        w_fin_set   = 1'b1;
`endif
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (w_word_end) begin
                    w_state_nxt = (w_word == r_chk) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (boot_start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_LEN;
                end
            end
            default: begin
                w_state_nxt = ST_LEN;
            end
        endcase
    end

    // in_ready is open in every collecting state. It closes as soon as the
    // final data byte has been taken.
    always_comb begin
        w_in_ready_nxt = 1'b0;
        if ((w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA)) begin
            w_in_ready_nxt = !w_fin_set;
        end
`ifdef BOOT_CHECKSUM_EN
        if (w_state_nxt == ST_CHK) begin
            w_in_ready_nxt = 1'b1;
        end
`endif
    end

    // Registered status outputs, aligned with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_cpu_reset <= (w_state_nxt != ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
            r_error     <= (w_state_nxt == ST_ERR);
        end
    end

    // Byte counter and little-endian byte assembly buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_byte_cnt <= 2'd0;
            r_buf      <= 24'd0;
        end else if (w_restart) begin
            r_byte_cnt <= 2'd0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0:    r_buf[7:0]   <= in_data;
                2'd1:    r_buf[15:8]  <= in_data;
                2'd2:    r_buf[23:16] <= in_data;
                default: r_buf        <= r_buf;
            endcase
        end
    end

    // Image length, word index and running write address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len  <= '0;
            r_k    <= '0;
            r_addr <= BASE_ADDR;
            r_fin  <= 1'b0;
        end else begin
            r_fin <= w_fin_set;
            if (w_restart) begin
                r_k    <= '0;
                r_addr <= BASE_ADDR;
            end else if ((r_state == ST_LEN) && w_word_end) begin
                r_len  <= w_word[KW-1:0];
                r_k    <= '0;
                r_addr <= BASE_ADDR;
            end else if (w_wr) begin
                r_k    <= r_k + KW'(1);
                r_addr <= r_addr + ADDR_STEP;
            end
        end
    end

    // Memory write port: address/data hold until the next write, and the
    // strobe lasts one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mwa <= BASE_ADDR;
            r_mwd <= 32'd0;
            r_mwr <= 1'b0;
        end else begin
            r_mwr <= w_wr;
            if (w_wr) begin
                r_mwa <= r_addr;
                r_mwd <= w_word;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running XOR of the data words, seeded with 0 for each image.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chk <= 32'd0;
        end else if ((r_state == ST_LEN) && w_word_end) begin
            r_chk <= 32'd0;
        end else if (w_wr) begin
            r_chk <= r_chk ^ w_word;
        end
    end
`endif

    assign in_ready    = r_in_ready;
    assign mwa_i       = r_mwa;
    assign mwd_i       = r_mwd;
    assign mwr_i       = r_mwr;
    assign cpu_reset   = r_cpu_reset;
    assign done        = r_done;
    assign error       = r_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed images plus random images.
// The expected write list and final outcome come from a word-level model.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] STEP = 32'd4;
  localparam int          MAXW = 256;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        boot_start = 1'b0;
  logic [31:0] mwa_i;
  logic [31:0] mwd_i;
  logic        mwr_i;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  imem_boot_loader #(
    .BASE_ADDR(BASE),
    .ADDR_STEP(STEP),
    .MAX_WORDS(MAXW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .boot_start(boot_start),
    .mwa_i(mwa_i),
    .mwd_i(mwd_i),
    .mwr_i(mwr_i),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [31:0] img_q[$];
  logic [63:0] exp_q[$];

  int cyc = 0;
  int wr_count = 0;
  int last_wr = -100;
  int done_rise = -100;
  int err_rise = -100;
  int last_acc = -100;
  logic prev_mwr = 1'b0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  function automatic void check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endfunction

  // Write monitor: each strobe must match the head of the expected queue and
  // last one cycle. Rising edges of done/error are time-stamped.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    prev_mwr <= mwr_i;
    prev_done <= done;
    prev_err <= error;
    if (mwr_i) begin
      wr_count <= wr_count + 1;
      last_wr <= cyc + 1;
      check("mwr_one_cycle", 64'(prev_mwr), 64'd0);
      if (exp_q.size() > 0) check("write", {mwa_i, mwd_i}, exp_q.pop_front());
      else check("unexpected_write", {mwa_i, mwd_i}, 64'h0000_0001_DEAD_BEEF);
    end
    if (done && !prev_done) done_rise <= cyc + 1;
    if (error && !prev_err) err_rise <= cyc + 1;
  end

  // ---------------- reference model ----------------
  // outcome: 1 = done, 2 = error. Pushes the expected {addr, data} writes.
  task automatic model_image(output int outcome, output int nwr);
    logic [31:0] n;
    logic [31:0] x;
    n = img_q[0];
    x = 32'd0;
    nwr = 0;
    if (n > 32'(MAXW)) begin
      outcome = 2;
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        exp_q.push_back({BASE + STEP * 32'(k), img_q[1 + k]});
        x = x ^ img_q[1 + k];
        nwr++;
      end
`ifdef BOOT_CHECKSUM_EN
      outcome = (img_q[int'(n) + 1] == x) ? 1 : 2;
`else
      outcome = 1;
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic gap);
    int t;
    if (gap) begin
      @(negedge clock); #1;
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
    @(negedge clock); #1;
    t = 0;
    while (!in_ready && t < 20) begin
      in_valid = 1'b0;
      @(negedge clock); #1;
      t++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data = b;
    last_acc = cyc;
  endtask

  task automatic do_boot();
    @(negedge clock); #1;
    boot_start = 1'b1;
    @(negedge clock); #1;
    boot_start = 1'b0;
    check("boot:cpu_reset", 64'(cpu_reset), 64'd1);
    check("boot:in_ready", 64'(in_ready), 64'd1);
    check("boot:done", 64'(done), 64'd0);
    check("boot:error", 64'(error), 64'd0);
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  task automatic run_image(input string tag, input int gap_mode);
    int outcome;
    int nwr;
    int start_wr;
    int t;
    logic [31:0] w;
    logic g;
    model_image(outcome, nwr);
    start_wr = wr_count;
    for (int i = 0; i < img_q.size(); i++) begin
      w = img_q[i];
      for (int b = 0; b < 4; b++) begin
        if (gap_mode == 1) g = 1'b1;
        else if (gap_mode == 2) g = 1'($urandom_range(0, 1));
        else g = 1'b0;
        send_byte(w[8*b +: 8], g);
      end
    end
    @(negedge clock); #1;
    in_valid = 1'b0;
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clock); #1;
      t++;
    end
    repeat (2) begin
      @(negedge clock); #1;
    end
    check({tag, ":writes"}, 64'(wr_count - start_wr), 64'(nwr));
    check({tag, ":exp_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check({tag, ":done"}, 64'(done), 64'(outcome == 1));
    check({tag, ":error"}, 64'(error), 64'(outcome == 2));
    check({tag, ":cpu_reset"}, 64'(cpu_reset), 64'(outcome != 1));
    check({tag, ":in_ready"}, 64'(in_ready), 64'd0);
    if (outcome == 2) begin
      check({tag, ":err_lat"}, 64'(err_rise - last_acc), 64'd1);
    end else begin
`ifdef BOOT_CHECKSUM_EN
      check({tag, ":done_lat"}, 64'(done_rise - last_acc), 64'd1);
`else
      if (nwr > 0) begin
        check({tag, ":wr_lat"}, 64'(last_wr - last_acc), 64'd1);
        check({tag, ":done_after_wr"}, 64'(done_rise - last_wr), 64'd1);
      end else begin
        check({tag, ":done_lat"}, 64'(done_rise - last_acc), 64'd1);
      end
`endif
    end
  endtask

  // Build an image from a length and a data list; checksum appended when enabled.
  task automatic build_image(input logic [31:0] n, input logic [31:0] d0, input logic [31:0] d1);
    img_q.delete();
    img_q.push_back(n);
    if (n >= 32'd1) img_q.push_back(d0);
    if (n >= 32'd2) img_q.push_back(d1);
`ifdef BOOT_CHECKSUM_EN
    img_q.push_back(((n >= 32'd1) ? d0 : 32'd0) ^ ((n >= 32'd2) ? d1 : 32'd0));
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] n;
    logic [31:0] w;
    logic [31:0] x;
    int sel;
    int start_wr;

    // Reset values.
    #1 reset = 1'b0;
    @(negedge clock); #1;
    check("rst:in_ready", 64'(in_ready), 64'd0);
    check("rst:mwa", 64'(mwa_i), 64'(BASE));
    check("rst:mwd", 64'(mwd_i), 64'd0);
    check("rst:mwr", 64'(mwr_i), 64'd0);
    check("rst:cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst:done", 64'(done), 64'd0);
    check("rst:error", 64'(error), 64'd0);
    @(negedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;
    check("post_rst:in_ready", 64'(in_ready), 64'd1);
    check("post_rst:cpu_reset", 64'(cpu_reset), 64'd1);

    // Basic two-word image.
    build_image(32'd2, 32'h2001_0005, 32'h0000_000C);
    run_image("n2", 0);

    // Empty image.
    do_boot();
    build_image(32'd0, 32'd0, 32'd0);
    run_image("n0", 0);

    // Oversized length: rejected immediately, no checksum word.
    do_boot();
    img_q.delete();
    img_q.push_back(32'(MAXW + 1));
    run_image("n257", 0);

    // Largest accepted length is not rejected at the length word.
    do_boot();
    img_q.delete();
    img_q.push_back(32'(MAXW));
    for (int k = 0; k < MAXW; k++) img_q.push_back(32'($urandom));
`ifdef BOOT_CHECKSUM_EN
    x = 32'd0;
    for (int k = 1; k <= MAXW; k++) x = x ^ img_q[k];
    img_q.push_back(x);
`endif
    run_image("nmax", 0);

`ifdef BOOT_CHECKSUM_EN
    do_boot();
    img_q.delete();
    img_q.push_back(32'd2);
    img_q.push_back(32'hFFFF_0000);
    img_q.push_back(32'h0000_FFFF);
    img_q.push_back(32'hFFFF_FFFF);
    run_image("chk_good", 0);
    do_boot();
    img_q.delete();
    img_q.push_back(32'd2);
    img_q.push_back(32'hFFFF_0000);
    img_q.push_back(32'h0000_FFFF);
    img_q.push_back(32'h0000_0000);
    run_image("chk_bad", 0);
`endif

    // Valid every other cycle over three words.
    do_boot();
    img_q.delete();
    img_q.push_back(32'd3);
    x = 32'd0;
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      img_q.push_back(w);
      x = x ^ w;
    end
`ifdef BOOT_CHECKSUM_EN
    img_q.push_back(x);
`endif
    run_image("gap3", 1);

    // Reset after six bytes: the partial word is never written, then a new image.
    do_boot();
    start_wr = wr_count;
    w = 32'd3;
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clock); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clock); #1;
    end
    check("partial:writes", 64'(wr_count - start_wr), 64'd0);
    check("partial:done", 64'(done), 64'd0);
    check("partial:in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(negedge clock); #1;
    check("midrst:in_ready", 64'(in_ready), 64'd0);
    check("midrst:cpu_reset", 64'(cpu_reset), 64'd1);
    reset = 1'b1;
    @(negedge clock); #1;
    check("midrst:ready_after", 64'(in_ready), 64'd1);
    build_image(32'd1, 32'h1234_5678, 32'd0);
    run_image("after_rst", 0);
    do_boot();
    build_image(32'd2, 32'($urandom), 32'($urandom));
    run_image("fresh_len", 2);

    // Random images.
    for (int r = 0; r < 12; r++) begin
      do_boot();
      img_q.delete();
      sel = $urandom_range(0, 9);
      if (sel == 0) n = 32'd0;
      else if (sel == 1) n = 32'($urandom_range(MAXW + 1, 100000));
      else if (sel == 2) n = 32'($urandom) | 32'h8000_0000;
      else n = 32'($urandom_range(1, 8));
      img_q.push_back(n);
      if (n <= 32'(MAXW)) begin
        x = 32'd0;
        for (int k = 0; k < int'(n); k++) begin
          w = $urandom;
          img_q.push_back(w);
          x = x ^ w;
        end
`ifdef BOOT_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) x = x ^ 32'($urandom_range(1, 255));
        img_q.push_back(x);
`endif
      end
      run_image("rand", $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
